// File: rtl/recip_counter_if.sv
// Measurement-side signals of recip_counter: channel inputs, run control,
// stretcher trigger/feedback and results. clk/rst stay plain module ports.
interface recip_counter_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int TMR_W    = 32,
  parameter int VRN_W    = 8,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] ch;
  logic                arm;
  logic                gate;
  logic                abort;
  logic [SEL_W-1:0]    strt_sel;
  logic [SEL_W-1:0]    stop_sel;
  logic [SEL_W-1:0]    cnt_sel;
  logic [1:0]          strt_edge;
  logic [1:0]          stop_edge;
  logic                cnt_edge;
  logic [1:0]          cal_mode;
  logic                strt_tac_out;
  logic                stop_tac_out;
  logic                strt_tac_fb;
  logic                stop_tac_fb;
  logic [CNT_W-1:0]    cnt_dout;
  logic [TMR_W-1:0]    tmr_dout;
  logic [VRN_W-1:0]    strt_dout;
  logic [VRN_W-1:0]    stop_dout;
  logic                valid;
  logic                busy;
  logic                ovf;
  logic                vrn_err;

  // valid is a one-cycle strobe with no ready/back-pressure: the consumer
  // must take the results in that cycle or read them later, since they hold
  // until the next strobe. arm is only accepted while busy is low.
  modport master (
    output ch, arm, gate, abort, strt_sel, stop_sel, cnt_sel,
           strt_edge, stop_edge, cnt_edge, cal_mode, strt_tac_fb, stop_tac_fb,
    input  strt_tac_out, stop_tac_out, cnt_dout, tmr_dout, strt_dout,
           stop_dout, valid, busy, ovf, vrn_err
  );

  modport slave (
    input  ch, arm, gate, abort, strt_sel, stop_sel, cnt_sel,
           strt_edge, stop_edge, cnt_edge, cal_mode, strt_tac_fb, stop_tac_fb,
    output strt_tac_out, stop_tac_out, cnt_dout, tmr_dout, strt_dout,
           stop_dout, valid, busy, ovf, vrn_err
  );
endinterface

// File: rtl/recip_counter.sv
// Reciprocal counter: start/stop interval timer, event counter and two
// independent vernier captures of externally stretched trigger pulses.
module recip_counter #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int TMR_W    = 32,
  parameter int VRN_W    = 8,
  parameter int TAC_LEN  = 4,
  parameter int VRN_TMO  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  recip_counter_if.slave        bus,
  output logic [2:0]            o_dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RUN, S_STOPPING, S_VERNIER, S_DONE
  } state_t;
  typedef enum logic [1:0] {V_IDLE, V_WAIT, V_CNT, V_DONE} vstate_t;

  localparam int TMO_W = $clog2(VRN_TMO + 1);
  localparam int LEN_W = $clog2(TAC_LEN + 2);
  localparam logic [VRN_W-1:0] VRN_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(VRN_TMO - 1);
  localparam logic [LEN_W-1:0] LEN_NORM = LEN_W'(TAC_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_CAL  = LEN_W'(TAC_LEN);

  state_t              r_state, w_state_nxt;
  logic                r_first;
  logic [CHANNELS-1:0] r_ch_s1, r_ch_s2, r_ch_d;
  logic [1:0]          r_fb_s1, r_fb_s2;
  logic [CNT_W-1:0]    r_cnt, r_cnt_out;
  logic [TMR_W-1:0]    r_tmr, r_tmr_out;
  logic                r_ovf, r_ovf_out, r_err_out;
  logic [VRN_W-1:0]    r_strt_out, r_stop_out;
  // Per-side arrays: index 0 is the start side, index 1 the stop side.
  logic [1:0]          r_tac;
  logic [LEN_W-1:0]    r_tac_left [2];
  vstate_t             r_vst [2];
  vstate_t             w_vst_nxt [2];
  logic [TMO_W-1:0]    r_tmo [2];
  logic [VRN_W-1:0]    r_vval [2];
  logic [1:0]          r_verr;

  logic [CHANNELS-1:0] w_rise, w_fall;
  logic                w_cal, w_strt_ev, w_stop_ev, w_cnt_ev, w_window;
  logic                w_arm_go, w_load;
  logic [1:0]          w_strt_mode, w_stop_mode, w_fire;

  function automatic logic edge_hit(input logic [1:0] mode, input logic rise,
                                    input logic fall, input logic first);
    case (mode)
      2'b00:   return rise;
      2'b01:   return fall;
      2'b10:   return rise | fall;
      default: return first;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ch_s1 <= '0;
      r_ch_s2 <= '0;
      r_ch_d  <= '0;
      r_fb_s1 <= '0;
      r_fb_s2 <= '0;
    end else begin
      r_ch_s1 <= bus.ch;
      r_ch_s2 <= r_ch_s1;
      r_ch_d  <= r_ch_s2;
      r_fb_s1 <= {bus.stop_tac_fb, bus.strt_tac_fb};
      r_fb_s2 <= r_fb_s1;
    end
  end

  assign w_rise      = r_ch_s2 & ~r_ch_d;
  assign w_fall      = ~r_ch_s2 & r_ch_d;
  assign w_cal       = (bus.cal_mode == 2'b01) || (bus.cal_mode == 2'b10);
  assign w_strt_mode = w_cal ? 2'b11 : bus.strt_edge;
  assign w_stop_mode = w_cal ? 2'b11 : bus.stop_edge;
  // r_first marks the first cycle of a state, which is when immediate mode fires.
  assign w_strt_ev   = (r_state == S_ARMED) &&
                       edge_hit(w_strt_mode, w_rise[bus.strt_sel], w_fall[bus.strt_sel], r_first);
  assign w_stop_ev   = (r_state == S_STOPPING) &&
                       edge_hit(w_stop_mode, w_rise[bus.stop_sel], w_fall[bus.stop_sel], r_first);
  assign w_cnt_ev    = bus.cnt_edge ? w_fall[bus.cnt_sel] : w_rise[bus.cnt_sel];
  assign w_window    = (r_state == S_RUN) || (r_state == S_STOPPING);
  assign w_fire      = {w_stop_ev, w_strt_ev};
  assign w_arm_go    = (r_state == S_IDLE) && (w_state_nxt == S_ARMED);
  assign w_load      = (r_state == S_VERNIER) && (w_state_nxt == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (bus.arm)   w_state_nxt = S_ARMED;
      S_ARMED:    if (w_strt_ev) w_state_nxt = S_RUN;
      S_RUN:      if (!bus.gate) w_state_nxt = S_STOPPING;
      S_STOPPING: if (w_stop_ev) w_state_nxt = S_VERNIER;
      S_VERNIER:  if (r_vst[0] == V_DONE && r_vst[1] == V_DONE) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (bus.abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_first    <= 1'b0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_ovf      <= 1'b0;
      r_cnt_out  <= '0;
      r_tmr_out  <= '0;
      r_strt_out <= '0;
      r_stop_out <= '0;
      r_ovf_out  <= 1'b0;
      r_err_out  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= (w_state_nxt != r_state);
      if (w_arm_go) begin
        r_cnt <= '0;
        r_tmr <= '0;
        r_ovf <= 1'b0;
      end else if (w_window) begin
        // Window spans start+1 .. stop inclusive, so tmr ends at stop - start.
        r_tmr <= r_tmr + 1'b1;
        if (&r_tmr) r_ovf <= 1'b1;
        if (w_cnt_ev) begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) r_ovf <= 1'b1;
        end
      end
      if (w_load) begin
        r_cnt_out  <= r_cnt;
        r_tmr_out  <= r_tmr;
        r_strt_out <= r_vval[0];
        r_stop_out <= r_vval[1];
        r_ovf_out  <= r_ovf;
        r_err_out  <= |r_verr;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_vst_nxt[s] = r_vst[s];
      case (r_vst[s])
        V_WAIT: begin
          if (r_fb_s2[s])               w_vst_nxt[s] = V_CNT;
          else if (r_tmo[s] == TMO_LAST) w_vst_nxt[s] = V_DONE;
        end
        V_CNT: if (!r_fb_s2[s] || r_vval[s] == VRN_MAX) w_vst_nxt[s] = V_DONE;
        default: ;
      endcase
      if (w_fire[s]) w_vst_nxt[s] = V_WAIT;
      if (bus.abort || w_arm_go) w_vst_nxt[s] = V_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst) begin
        r_vst[s]      <= V_IDLE;
        r_tmo[s]      <= '0;
        r_vval[s]     <= '0;
        r_verr[s]     <= 1'b0;
        r_tac[s]      <= 1'b0;
        r_tac_left[s] <= '0;
      end else begin
        r_vst[s] <= w_vst_nxt[s];
        if (w_fire[s]) begin
          r_tmo[s]  <= '0;
          r_vval[s] <= '0;
          r_verr[s] <= 1'b0;
        end else if (r_vst[s] == V_WAIT) begin
          if (r_fb_s2[s]) begin
            r_vval[s] <= VRN_W'(1);
          end else if (r_tmo[s] == TMO_LAST) begin
            r_vval[s] <= VRN_MAX;
            r_verr[s] <= 1'b1;
          end else begin
            r_tmo[s] <= r_tmo[s] + 1'b1;
          end
        end else if (r_vst[s] == V_CNT && r_fb_s2[s]) begin
          if (r_vval[s] == VRN_MAX) r_verr[s] <= 1'b1;
          else                      r_vval[s] <= r_vval[s] + 1'b1;
        end

        if (bus.abort) begin
          r_tac[s] <= 1'b0;
        end else if (w_fire[s]) begin
          r_tac[s]      <= 1'b1;
          r_tac_left[s] <= (bus.cal_mode == 2'b10) ? LEN_CAL : LEN_NORM;
        end else if (r_tac[s]) begin
          if (r_tac_left[s] == '0) r_tac[s] <= 1'b0;
          else                     r_tac_left[s] <= r_tac_left[s] - 1'b1;
        end
      end
    end
  end

  assign bus.strt_tac_out = r_tac[0];
  assign bus.stop_tac_out = r_tac[1];
  assign bus.cnt_dout     = r_cnt_out;
  assign bus.tmr_dout     = r_tmr_out;
  assign bus.strt_dout    = r_strt_out;
  assign bus.stop_dout    = r_stop_out;
  assign bus.ovf          = r_ovf_out;
  assign bus.vrn_err      = r_err_out;
  assign bus.valid        = (r_state == S_DONE);
  assign bus.busy         = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_recip_counter.sv
// Directed and randomized bench for recip_counter; a second instance with an
// 8-bit counter shares the stimulus to exercise counter wrap.
module tb_recip_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] dbg_state, dbg_state8;

  recip_counter_if #(.CHANNELS(4), .CNT_W(32), .TMR_W(32), .VRN_W(8)) bus ();
  recip_counter_if #(.CHANNELS(4), .CNT_W(8),  .TMR_W(32), .VRN_W(8)) bus8 ();

  recip_counter #(.CHANNELS(4), .CNT_W(32), .TMR_W(32), .VRN_W(8), .TAC_LEN(4), .VRN_TMO(64))
    dut (.clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state));
  recip_counter #(.CHANNELS(4), .CNT_W(8), .TMR_W(32), .VRN_W(8), .TAC_LEN(4), .VRN_TMO(64))
    dut8 (.clk(clk), .rst(rst), .bus(bus8), .o_dbg_state(dbg_state8));

  assign bus8.ch          = bus.ch;
  assign bus8.arm         = bus.arm;
  assign bus8.gate        = bus.gate;
  assign bus8.abort       = bus.abort;
  assign bus8.strt_sel    = bus.strt_sel;
  assign bus8.stop_sel    = bus.stop_sel;
  assign bus8.cnt_sel     = bus.cnt_sel;
  assign bus8.strt_edge   = bus.strt_edge;
  assign bus8.stop_edge   = bus.stop_edge;
  assign bus8.cnt_edge    = bus.cnt_edge;
  assign bus8.cal_mode    = bus.cal_mode;
  assign bus8.strt_tac_fb = bus.strt_tac_fb;
  assign bus8.stop_tac_fb = bus.stop_tac_fb;

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- monitors ----------------
  int n_valid = 0, t_valid = 0, t_stop_rise = 0;
  int strt_run = 0, stop_run = 0, strt_w_last = 0, stop_w_last = 0;
  logic prev_strt = 1'b0, prev_stop = 1'b0;
  always @(negedge clk) begin
    if (bus.valid) begin n_valid++; t_valid = cyc; end
    if (bus.stop_tac_out && !prev_stop) t_stop_rise = cyc;
    if (bus.strt_tac_out) strt_run++;
    else if (prev_strt) begin strt_w_last = strt_run; strt_run = 0; end
    if (bus.stop_tac_out) stop_run++;
    else if (prev_stop) begin stop_w_last = stop_run; stop_run = 0; end
    prev_strt = bus.strt_tac_out;
    prev_stop = bus.stop_tac_out;
  end

  // ---------------- stretcher feedback model ----------------
  int strt_fb_dly = 3, strt_fb_w = 47, stop_fb_dly = 3, stop_fb_w = 47;
  bit strt_fb_en = 1'b1, stop_fb_en = 1'b1;
  initial begin : fb_strt
    logic prev;
    prev = 1'b0;
    bus.strt_tac_fb = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.strt_tac_out && !prev && strt_fb_en) begin
        repeat (strt_fb_dly) @(negedge clk);
        bus.strt_tac_fb = 1'b1;
        repeat (strt_fb_w) @(negedge clk);
        bus.strt_tac_fb = 1'b0;
      end
      prev = bus.strt_tac_out;
    end
  end
  initial begin : fb_stop
    logic prev;
    prev = 1'b0;
    bus.stop_tac_fb = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.stop_tac_out && !prev && stop_fb_en) begin
        repeat (stop_fb_dly) @(negedge clk);
        bus.stop_tac_fb = 1'b1;
        repeat (stop_fb_w) @(negedge clk);
        bus.stop_tac_fb = 1'b0;
      end
      prev = bus.stop_tac_out;
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  int n_checks = 0, n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick(1);
    bus.arm = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int base);
    int k;
    k = 0;
    while (n_valid == base && k < 3000) begin
      tick(1);
      k++;
    end
    chk({tag, "_valid_seen"}, 64'(n_valid > base), 64'd1);
    tick(3);
    chk({tag, "_valid_once"}, 64'(n_valid), 64'(base + 1));
    chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt"},   64'(bus.cnt_dout), 64'd0);
    chk({tag, "_tmr"},   64'(bus.tmr_dout), 64'd0);
    chk({tag, "_strt"},  64'(bus.strt_dout), 64'd0);
    chk({tag, "_stop"},  64'(bus.stop_dout), 64'd0);
    chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy), 64'd0);
    chk({tag, "_ovf"},   64'(bus.ovf), 64'd0);
    chk({tag, "_err"},   64'(bus.vrn_err), 64'd0);
    chk({tag, "_stac"},  64'(bus.strt_tac_out), 64'd0);
    chk({tag, "_ptac"},  64'(bus.stop_tac_out), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, d, ce, exp_cnt, last_cnt, last_tmr;
    logic cur;
    bus.ch = '0; bus.arm = 1'b0; bus.gate = 1'b1; bus.abort = 1'b0;
    bus.strt_sel = '0; bus.stop_sel = '0; bus.cnt_sel = '0;
    bus.strt_edge = 2'b00; bus.stop_edge = 2'b00; bus.cnt_edge = 1'b0;
    bus.cal_mode = 2'b00;
    tick(4);
    chk_all_zero("reset");
    rst = 1'b1;
    tick(2);

    // Frequency: ch0 period 32, gate drops 100 cycles into the run.
    base = n_valid;
    do_arm();
    tick(2);
    for (int c = 0; c < 172; c++) begin
      bus.ch[0] = ((c / 16) % 2 == 0);
      if (c == 100) bus.gate = 1'b0;
      tick(1);
    end
    bus.ch[0] = 1'b0;
    wait_valid("freq", base);
    chk("freq_cnt",  64'(bus.cnt_dout), 64'd4);
    chk("freq_tmr",  64'(bus.tmr_dout), 64'd128);
    chk("freq_strt", 64'(bus.strt_dout), 64'd47);
    chk("freq_stop", 64'(bus.stop_dout), 64'd47);
    chk("freq_ovf",  64'(bus.ovf), 64'd0);
    chk("freq_err",  64'(bus.vrn_err), 64'd0);
    bus.gate = 1'b1;
    tick(4);

    // Time interval: ch1 rise to ch2 rise, 37 cycles apart.
    bus.strt_sel = 2'd1; bus.stop_sel = 2'd2; bus.cnt_sel = 2'd3;
    bus.gate = 1'b0;
    base = n_valid;
    do_arm();
    tick(4);
    bus.ch[1] = 1'b1;
    tick(37);
    bus.ch[2] = 1'b1;
    wait_valid("ti", base);
    chk("ti_tmr", 64'(bus.tmr_dout), 64'd37);
    chk("ti_cnt", 64'(bus.cnt_dout), 64'd0);
    chk("ti_ovf", 64'(bus.ovf), 64'd0);
    bus.ch[1] = 1'b0; bus.ch[2] = 1'b0;
    tick(4);

    // Vernier timeout on the stop side.
    stop_fb_en = 1'b0;
    base = n_valid;
    do_arm();
    tick(4);
    bus.ch[1] = 1'b1;
    tick(20);
    bus.ch[2] = 1'b1;
    wait_valid("tmo", base);
    chk("tmo_stop", 64'(bus.stop_dout), 64'd255);
    chk("tmo_strt", 64'(bus.strt_dout), 64'd47);
    chk("tmo_err",  64'(bus.vrn_err), 64'd1);
    chk("tmo_tmr",  64'(bus.tmr_dout), 64'd20);
    chk("tmo_latency_64_70", 64'((t_valid - t_stop_rise) >= 64 && (t_valid - t_stop_rise) <= 70), 64'd1);
    stop_fb_en = 1'b1;
    bus.ch[1] = 1'b0; bus.ch[2] = 1'b0;
    tick(4);

    // Calibration: both modes force immediate start/stop.
    for (int m = 1; m <= 2; m++) begin
      bus.cal_mode = 2'(m);
      strt_w_last = 0; stop_w_last = 0;
      base = n_valid;
      do_arm();
      wait_valid("cal", base);
      chk("cal_strt_width", 64'(strt_w_last), 64'(m == 2 ? 5 : 4));
      chk("cal_stop_width", 64'(stop_w_last), 64'(m == 2 ? 5 : 4));
      chk("cal_tmr",  64'(bus.tmr_dout), 64'd2);
      chk("cal_strt", 64'(bus.strt_dout), 64'd47);
      chk("cal_err",  64'(bus.vrn_err), 64'd0);
      tick(4);
    end
    bus.cal_mode = 2'b00;
    bus.gate = 1'b1;

    // Overflow: 300 count events, 8-bit instance wraps to 44.
    bus.strt_edge = 2'b11; bus.stop_edge = 2'b11;
    base = n_valid;
    do_arm();
    tick(4);
    for (int i = 0; i < 300; i++) begin
      bus.ch[3] = 1'b1; tick(2);
      bus.ch[3] = 1'b0; tick(2);
    end
    tick(4);
    bus.gate = 1'b0;
    wait_valid("ovf", base);
    chk("ovf_cnt32", 64'(bus.cnt_dout), 64'd300);
    chk("ovf_flag32", 64'(bus.ovf), 64'd0);
    chk("ovf_cnt8", 64'(bus8.cnt_dout), 64'd44);
    chk("ovf_flag8", 64'(bus8.ovf), 64'd1);
    bus.strt_edge = 2'b00; bus.stop_edge = 2'b00;
    tick(4);

    // Randomized interval/count runs against a window-counting model.
    last_cnt = 0; last_tmr = 0;
    for (int r = 0; r < 6; r++) begin
      d  = $urandom_range(10, 150);
      ce = $urandom_range(0, 1);
      strt_fb_dly = $urandom_range(1, 20); strt_fb_w = $urandom_range(1, 150);
      stop_fb_dly = $urandom_range(1, 20); stop_fb_w = $urandom_range(1, 150);
      bus.cnt_edge = ce[0];
      bus.ch[3] = 1'b0; cur = 1'b0;
      exp_cnt = 0;
      tick(2);
      base = n_valid;
      do_arm();
      tick(4);
      for (int t = -6; t <= d + 6; t++) begin
        if (t == 0) bus.ch[1] = 1'b1;
        if (t == d) bus.ch[2] = 1'b1;
        if (t == 0 || t == d || $urandom_range(0, 3) == 0) begin
          cur = ~cur;
          bus.ch[3] = cur;
          if (t > 0 && t <= d && cur == !ce[0]) exp_cnt++;
        end
        tick(1);
      end
      exp_q.push_back(32'(exp_cnt));
      exp_q.push_back(32'(d));
      exp_q.push_back(32'(strt_fb_w));
      exp_q.push_back(32'(stop_fb_w));
      wait_valid("rnd", base);
      chk("rnd_cnt",  64'(bus.cnt_dout),  64'(exp_q.pop_front()));
      chk("rnd_tmr",  64'(bus.tmr_dout),  64'(exp_q.pop_front()));
      chk("rnd_strt", 64'(bus.strt_dout), 64'(exp_q.pop_front()));
      chk("rnd_stop", 64'(bus.stop_dout), 64'(exp_q.pop_front()));
      chk("rnd_err",  64'(bus.vrn_err), 64'd0);
      last_cnt = exp_cnt; last_tmr = d;
      bus.ch[1] = 1'b0; bus.ch[2] = 1'b0;
      tick(4);
    end
    strt_fb_dly = 3; strt_fb_w = 47; stop_fb_dly = 3; stop_fb_w = 100;
    bus.cnt_edge = 1'b0;

    // Abort while the stop capture is in flight: no valid, results retained.
    base = n_valid;
    do_arm();
    tick(4);
    bus.ch[1] = 1'b1;
    tick(20);
    bus.ch[2] = 1'b1;
    tick(12);
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("abort_busy_after", 64'(bus.busy), 64'd0);
    tick(200);
    chk("abort_no_valid", 64'(n_valid), 64'(base));
    chk("abort_keep_cnt", 64'(bus.cnt_dout), 64'(last_cnt));
    chk("abort_keep_tmr", 64'(bus.tmr_dout), 64'(last_tmr));
    bus.ch[1] = 1'b0; bus.ch[2] = 1'b0;
    bus.gate = 1'b1;
    tick(4);

    // Reset asserted mid-RUN clears every output at the next edge.
    do_arm();
    tick(4);
    bus.ch[1] = 1'b1;
    tick(10);
    chk("rstrun_busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    tick(1);
    chk_all_zero("rstrun");
    rst = 1'b1;
    bus.ch[1] = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/recip_counter.md
# recip_counter

Parametrised reciprocal counter with per-event vernier capture. It is the next-generation core of the frequency/time-interval front end. The block selects start, stop and count events from CHANNELS asynchronous inputs and measures the start-to-stop interval in clk cycles, counting events of the count channel in parallel. It drives an external time-to-amplitude stretcher for start and stop, and digitises the returned stretched pulses as vernier fractions. It supports zero-scale and full-scale calibration runs.

## Interface
- CHANNELS, 4, number of asynchronous input channels; SEL_W = max(1, $clog2(CHANNELS))
- CNT_W, 32, event counter width
- TMR_W, 32, interval timer width
- VRN_W, 8, vernier result width
- TAC_LEN, 4, stretcher trigger pulse length in clk cycles
- VRN_TMO, 64, cycles allowed from trigger rise to first synchronised feedback high
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- ch  in  CHANNELS  asynchronous input channels
- arm  in  1  start a measurement; sampled in IDLE
- gate  in  1  1 = keep running; 0 = stop at the next stop event
- abort  in  1  return to IDLE immediately, no result
- strt_sel, stop_sel, cnt_sel  in  SEL_W  channel index for start, stop and count events
- strt_edge, stop_edge  in  2  00 rising, 01 falling, 10 both, 11 immediate
- cnt_edge  in  1  0 rising, 1 falling
- cal_mode  in  2  00 normal, 01 zero scale, 10 full scale, 11 as 00
- strt_tac_out, stop_tac_out  out  1  stretcher trigger
- strt_tac_fb, stop_tac_fb  in  1  stretched pulse returned (asynchronous)
- cnt_dout  out  CNT_W  counted events
- tmr_dout  out  TMR_W  start-to-stop interval in clk cycles
- strt_dout, stop_dout  out  VRN_W  vernier fractions
- valid  out  1  one-cycle pulse when results update
- busy  out  1  state != IDLE
- ovf  out  1  counter or timer wrapped during the run
- vrn_err  out  1  a vernier capture saturated or timed out

## Operation
- Each ch bit passes through a 2-FF synchroniser. An edge register follows it, and an event is asserted in the cycle where the synchronised value differs from the previous one. Feedback inputs use the same synchronisers.
- State machine:
  - IDLE: arm=1 moves to ARMED and clears the counter, timer and flags.
  - ARMED: the start event moves to RUN and fires the start trigger.
  - RUN: moves to STOPPING in the first cycle gate=0.
  - STOPPING: the stop event moves to VERNIER and fires the stop trigger.
  - VERNIER: moves to DONE once both vernier captures have finished.
  - DONE: loads the outputs, pulses valid and moves to IDLE.
  - abort=1 in any state: to IDLE. Outputs are not loaded and in-flight captures are discarded.
- Immediate edge mode (11): the event fires in the first cycle of ARMED (start) or STOPPING (stop).
- A stop event is never recognised in the same cycle as the start event.
- Timer: tmr_dout equals the stop-event cycle index minus the start-event cycle index.
- Counter: counts cnt_sel events in cycles after the start cycle, up to and including the stop cycle.
  - A count event coincident with the start event is not counted.
  - A count event coincident with the stop event is counted.
- Counter and timer wrap modulo 2^W; either wrap sets ovf for the run.
- Trigger pulses: the trigger rises in the cycle after the event and stays high for TAC_LEN cycles, or TAC_LEN+1 cycles when cal_mode=10.
- Calibration: cal_mode 01 or 10 forces both start and stop to immediate mode; cal_mode 01 gives a TAC_LEN pulse and 10 gives TAC_LEN+1.
- Vernier capture, run independently per side:
  - After the trigger rises, wait for synchronised fb=1. If no high is seen within VRN_TMO cycles, the result is 2^VRN_W-1 and vrn_err is set.
  - Count the cycles in which the synchronised fb is high. The capture ends on fb falling, or saturates at 2^VRN_W-1 and sets vrn_err.
- Outputs hold their values from DONE until the next DONE.

## Timing
- Reset: state IDLE. All outputs are 0: both triggers, cnt_dout, tmr_dout, both vernier results, valid, busy, ovf and vrn_err. Reset applies mid-run as well, taking effect at the next clk edge.
- Input-to-event latency: 3 clk edges.
- Trigger latency: 1 cycle after the event cycle.
- Feedback-to-count latency: 2 cycles. Fraction = synchronised high width.
- DONE follows the final capture completion by 1 cycle. valid is high during DONE, and busy drops 1 cycle after valid.
- arm is ignored while busy=1. gate and the select/edge/mode inputs are sampled each cycle and must be held stable while busy.

## Test plan
The bench uses CHANNELS=4, CNT_W=32, VRN_W=8, TAC_LEN=4 and VRN_TMO=64. The feedback model returns high 3 cycles after the trigger rises and holds it for 47 cycles.
- Frequency: ch0 toggles every 16 cycles, with start, stop and count all on ch0 rising. Drop gate 100 cycles after the start event -> cnt_dout=4, tmr_dout=128, strt_dout=47, stop_dout=47, one valid pulse.
- Time interval: start on ch1 rising, stop on ch2 rising 37 cycles later, gate=0 from arm -> tmr_dout=37, ovf=0.
- Vernier timeout: stop_tac_fb held at 0 -> stop_dout=255, vrn_err=1, valid asserted about 64+ cycles after the stop trigger.
- Calibration: cal_mode=01 with arm -> strt_tac_out high for exactly 4 cycles. cal_mode=10 -> high for 5 cycles, tmr_dout reflects immediate start/stop.
- Overflow: instance with CNT_W=8 and 300 count events in the run -> cnt_dout=44, ovf=1.
- Reset/abort: rst=0 mid-RUN -> all outputs 0 next cycle. abort mid-VERNIER -> IDLE, no valid, previous results retained.
